// File: rtl/snax_csr_bank_pkg.sv
// Shared types and address-map helpers for the accelerator-side CSR bank.
package snax_csr_bank_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Fixed CSRs sit directly above the read/write configuration block.
  function automatic logic [31:0] start_idx(int unsigned num_rw);
    return 32'(num_rw);
  endfunction

  function automatic logic [31:0] status_idx(int unsigned num_rw);
    return 32'(num_rw + 1);
  endfunction

  function automatic logic [31:0] cycles_idx(int unsigned num_rw);
    return 32'(num_rw + 2);
  endfunction

  function automatic logic [31:0] ro_base_idx(int unsigned num_rw);
    return 32'(num_rw + 3);
  endfunction

endpackage

// File: rtl/snax_csr_bank_if.sv
// Simplified CSR request/response stream between the translator and a CSR bank.
interface snax_csr_bank_if;

  logic [31:0] req_data;
  logic [31:0] req_addr;
  logic        req_write;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output req_data, req_addr, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  req_data, req_addr, req_write, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_valid
  );

endinterface

// File: rtl/snax_csr_rsp_buf.sv
// Single-entry valid/ready response register with a 32-bit payload.
module snax_csr_rsp_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i
);

  logic        valid_q;
  logic [31:0] data_q;

  // Refill in the same cycle the held entry drains.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_csr_bank.sv
// Accelerator CSR bank: shadow config registers, START commit, run tracking and
// registered read responses.
module snax_csr_bank
  import snax_csr_bank_pkg::*;
#(
  parameter int unsigned NumRwCsr = 8,
  parameter int unsigned NumRoCsr = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  snax_csr_bank_if.slave        csr,
  output logic [32*NumRwCsr-1:0] acc_cfg_o,
  output logic                  acc_start_o,
  input  logic                  acc_done_i,
  input  logic [32*NumRoCsr-1:0] acc_ro_csr_i,
  output logic                  busy_o
);

  localparam logic [31:0] StartIdx  = start_idx(NumRwCsr);
  localparam logic [31:0] StatusIdx = status_idx(NumRwCsr);
  localparam logic [31:0] CyclesIdx = cycles_idx(NumRwCsr);
  localparam logic [31:0] RoBaseIdx = ro_base_idx(NumRwCsr);

  logic [NumRwCsr-1:0][31:0] shadow_q;
  logic [NumRwCsr-1:0][31:0] cfg_q;
  logic [31:0]               cycles_q;
  logic [31:0]               rdata;
  state_e                    state_q, state_d;
  logic                      start_q;
  logic                      launch;
  logic                      is_start;
  logic                      stall;
  logic                      buf_ready;
  logic                      accept;
  logic                      wr_en;
  logic                      rd_en;

  // A START write during a run is held off until the first idle cycle.
  assign is_start      = csr.req_addr == StartIdx;
  assign stall         = csr.req_write && is_start && (state_q == StBusy);
  assign csr.req_ready = !stall && buf_ready;
  assign accept        = csr.req_valid && csr.req_ready;
  assign wr_en         = accept && csr.req_write;
  assign rd_en         = accept && !csr.req_write;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NumRwCsr; i++) begin
      if (csr.req_addr == 32'(i)) rdata = shadow_q[i];
    end
    if (csr.req_addr == StatusIdx) rdata = {31'd0, state_q == StBusy};
    if (csr.req_addr == CyclesIdx) rdata = cycles_q;
    for (int unsigned i = 0; i < NumRoCsr; i++) begin
      if (csr.req_addr == RoBaseIdx + 32'(i)) rdata = acc_ro_csr_i[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      StIdle: begin
        if (wr_en && is_start) begin
          state_d = StBusy;
          launch  = 1'b1;
        end
      end
      StBusy: begin
        if (acc_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      shadow_q <= '0;
      cfg_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= launch;
      for (int unsigned i = 0; i < NumRwCsr; i++) begin
        if (wr_en && csr.req_addr == 32'(i)) shadow_q[i] <= csr.req_data;
      end
      if (launch) begin
        cfg_q    <= shadow_q;
        cycles_q <= '0;
      end else if (state_q == StBusy && cycles_q != '1) begin
        cycles_q <= cycles_q + 32'd1;
      end
    end
  end

  snax_csr_rsp_buf u_rsp_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rd_en),
    .in_data_i   (rdata),
    .in_ready_o  (buf_ready),
    .out_valid_o (csr.rsp_valid),
    .out_data_o  (csr.rsp_data),
    .out_ready_i (csr.rsp_ready)
  );

  assign acc_cfg_o   = cfg_q;
  assign acc_start_o = start_q;
  assign busy_o      = state_q == StBusy;

endmodule

// File: tb/tb_snax_csr_bank.sv
// Self-checking bench for snax_csr_bank: table-driven accesses plus run/backpressure sequences.
module tb_snax_csr_bank;

  localparam int unsigned NumRwCsr = 8;
  localparam int unsigned NumRoCsr = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snax_csr_bank_if csr_if ();

  logic [32*NumRwCsr-1:0] acc_cfg;
  logic                   acc_start;
  logic                   acc_done;
  logic [32*NumRoCsr-1:0] acc_ro;
  logic                   busy;

  snax_csr_bank #(
    .NumRwCsr (NumRwCsr),
    .NumRoCsr (NumRoCsr)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr          (csr_if),
    .acc_cfg_o    (acc_cfg),
    .acc_start_o  (acc_start),
    .acc_done_i   (acc_done),
    .acc_ro_csr_i (acc_ro),
    .busy_o       (busy)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int n_rsp   = 0;
  int n_reads = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] cfg(input int i);
    return acc_cfg[32*i +: 32];
  endfunction

  // Scoreboard: every handshaken response pops the oldest expected read value.
  always @(negedge clk) begin
    if (!rst && csr_if.rsp_valid && csr_if.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got 0x%08h, want no response", csr_if.rsp_data);
      end else begin
        check("rsp_data", csr_if.rsp_data, exp_q.pop_front());
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic req(input logic write, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp);
    bit ok = 1'b0;
    csr_if.req_write = write;
    csr_if.req_addr  = addr;
    csr_if.req_data  = data;
    csr_if.req_valid = 1'b1;
    if (!write) begin
      exp_q.push_back(exp);
      n_reads++;
    end
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (csr_if.req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    csr_if.req_valid = 1'b0;
    csr_if.req_write = 1'b0;
    check("req_accepted", {31'd0, ok}, 32'd1);
    if (!ok && !write) begin
      void'(exp_q.pop_back());
      n_reads--;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];

  initial begin
    csr_if.req_valid = 1'b0;
    csr_if.req_write = 1'b0;
    csr_if.req_addr  = '0;
    csr_if.req_data  = '0;
    csr_if.rsp_ready = 1'b1;
    acc_done         = 1'b0;
    acc_ro           = {32'h0000_CAFE, 32'h1111_2222};

    vecs[0]  = '{1'b0, 32'd0,  32'd0,          32'd0};
    vecs[1]  = '{1'b1, 32'd3,  32'hDEAD_BEEF,  32'd0};
    vecs[2]  = '{1'b1, 32'd0,  32'hA5A5_0001,  32'd0};
    vecs[3]  = '{1'b1, 32'd7,  32'h7777_0007,  32'd0};
    vecs[4]  = '{1'b0, 32'd3,  32'd0,          32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 32'd0,  32'd0,          32'hA5A5_0001};
    vecs[6]  = '{1'b0, 32'd7,  32'd0,          32'h7777_0007};
    vecs[7]  = '{1'b0, 32'd8,  32'd0,          32'd0};
    vecs[8]  = '{1'b0, 32'd9,  32'd0,          32'd0};
    vecs[9]  = '{1'b0, 32'd10, 32'd0,          32'd0};
    vecs[10] = '{1'b0, 32'd11, 32'd0,          32'h1111_2222};
    vecs[11] = '{1'b0, 32'd12, 32'd0,          32'h0000_CAFE};
    vecs[12] = '{1'b1, 32'd9,  32'h0000_1234,  32'd0};
    vecs[13] = '{1'b1, 32'd20, 32'h0000_1234,  32'd0};
    vecs[14] = '{1'b1, 32'd13, 32'h0000_1234,  32'd0};
    vecs[15] = '{1'b0, 32'd20, 32'd0,          32'd0};
    vecs[16] = '{1'b0, 32'd13, 32'd0,          32'd0};
    vecs[17] = '{1'b0, 32'hFFFF_FFFF, 32'd0,   32'd0};
    vecs[18] = '{1'b0, 32'd9,  32'd0,          32'd0};

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, acc_start}, 32'd0);
    check("rst_rsp_valid", {31'd0, csr_if.rsp_valid}, 32'd0);
    check("rst_cfg_nonzero", {31'd0, |acc_cfg}, 32'd0);
    check("rst_req_ready", {31'd0, csr_if.req_ready}, 32'd1);
    cycle();

    // Register map sweep while idle
    for (int i = 0; i < 19; i++) req(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].exp);
    check("cfg_before_start", {31'd0, |acc_cfg}, 32'd0);
    check("busy_before_start", {31'd0, busy}, 32'd0);

    // Run 1: commit, shadow write during run, STATUS read in the done cycle
    req(1'b1, 32'd8, 32'd1, 32'd0);
    check("run1_start_pulse", {31'd0, acc_start}, 32'd1);
    check("run1_busy", {31'd0, busy}, 32'd1);
    check("run1_cfg3", cfg(3), 32'hDEAD_BEEF);
    check("run1_cfg0", cfg(0), 32'hA5A5_0001);
    check("run1_cfg7", cfg(7), 32'h7777_0007);
    req(1'b1, 32'd3, 32'h5, 32'd0);
    check("run1_start_one_cycle", {31'd0, acc_start}, 32'd0);
    check("run1_cfg3_held", cfg(3), 32'hDEAD_BEEF);
    repeat (4) cycle();
    acc_done = 1'b1;
    req(1'b0, 32'd9, 32'd0, 32'd1);
    acc_done = 1'b0;
    check("run1_idle_after_done", {31'd0, busy}, 32'd0);
    req(1'b0, 32'd10, 32'd0, 32'd6);
    req(1'b0, 32'd3, 32'd0, 32'd5);

    // Done while idle is ignored
    acc_done = 1'b1;
    cycle();
    acc_done = 1'b0;
    check("idle_done_busy", {31'd0, busy}, 32'd0);
    req(1'b0, 32'd10, 32'd0, 32'd6);

    // Run 2: START held while busy, accepted the cycle after done
    req(1'b1, 32'd8, 32'd0, 32'd0);
    check("run2_start_pulse", {31'd0, acc_start}, 32'd1);
    csr_if.req_valid = 1'b1;
    csr_if.req_write = 1'b1;
    csr_if.req_addr  = 32'd8;
    @(negedge clk);
    check("stall_ready_p1", {31'd0, csr_if.req_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge clk);
      check("stall_ready", {31'd0, csr_if.req_ready}, 32'd0);
    end
    cycle();
    acc_done = 1'b1;
    @(negedge clk);
    check("stall_ready_done_cycle", {31'd0, csr_if.req_ready}, 32'd0);
    cycle();
    acc_done = 1'b0;
    @(negedge clk);
    check("stall_ready_after_done", {31'd0, csr_if.req_ready}, 32'd1);
    check("stall_busy_after_done", {31'd0, busy}, 32'd0);
    cycle();
    csr_if.req_valid = 1'b0;
    csr_if.req_write = 1'b0;
    check("run3_start_pulse", {31'd0, acc_start}, 32'd1);
    check("run3_busy", {31'd0, busy}, 32'd1);
    cycle();
    check("run3_start_one_cycle", {31'd0, acc_start}, 32'd0);
    acc_done = 1'b1;
    cycle();
    acc_done = 1'b0;
    req(1'b0, 32'd10, 32'd0, 32'd2);

    // Response backpressure during run 4
    req(1'b1, 32'd8, 32'd0, 32'd0);
    csr_if.rsp_ready = 1'b0;
    req(1'b0, 32'd9, 32'd0, 32'd1);
    csr_if.req_valid = 1'b1;
    csr_if.req_write = 1'b0;
    csr_if.req_addr  = 32'd11;
    exp_q.push_back(32'h1111_2222);
    n_reads++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready", {31'd0, csr_if.req_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, csr_if.rsp_valid}, 32'd1);
      check("bp_rsp_data", csr_if.rsp_data, 32'd1);
      cycle();
    end
    csr_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, csr_if.req_ready}, 32'd1);
    cycle();
    csr_if.req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_rsp_valid", {31'd0, csr_if.rsp_valid}, 32'd1);
    cycle();
    check("bp_drained", {31'd0, csr_if.rsp_valid}, 32'd0);
    acc_done = 1'b1;
    cycle();
    acc_done = 1'b0;

    // Reset mid-run with a response pending
    req(1'b1, 32'd8, 32'd0, 32'd0);
    csr_if.rsp_ready = 1'b0;
    req(1'b0, 32'd9, 32'd0, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_reads--;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, csr_if.rsp_valid}, 32'd0);
    check("mid_rst_start", {31'd0, acc_start}, 32'd0);
    check("mid_rst_cfg3", cfg(3), 32'd0);
    csr_if.rsp_ready = 1'b1;
    acc_done = 1'b1;
    cycle();
    acc_done = 1'b0;
    check("late_done_busy", {31'd0, busy}, 32'd0);
    check("late_done_start", {31'd0, acc_start}, 32'd0);
    req(1'b0, 32'd10, 32'd0, 32'd0);
    req(1'b0, 32'd3, 32'd0, 32'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    repeat (2) cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("rsp_count", 32'(n_rsp), 32'(n_reads));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
